wdest_pipe: RTL and testbench

Parametrised write-destination selector and tracker for the pipelined MIPS core.
- Picks the write register for the instruction in ID: rd, rt, or the link register for jal.
- Carries the destination, write-enable and load flag through STAGES pipeline registers (EX, MEM, WB by default).
- Reports per-stage RAW matches against the ID-stage rs/rt, plus a load-use stall request, to the forwarding and hazard logic.

---
 rtl/mips_pipe_pkg.sv | 15 +
 rtl/wdest_stage_reg.sv | 30 +++
 rtl/wdest_pipe.sv | 119 +++++++++++
 tb/tb_wdest_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared constants and the pipeline-entry type for the MIPS core's
// write-destination tracking.
package mips_pipe_pkg;

  localparam int REG_ZERO     = 0;
  localparam int LINK_REG_DEF = 31;
  localparam int AW_DEF       = 5;

  typedef struct packed {
    logic [AW_DEF-1:0] dest;
    logic              wen;
    logic              load;
  } stage_entry_t;

endpackage

// File: rtl/wdest_stage_reg.sv
// One pipeline slot of the destination tracker: {dest, wen, load}, cleared
// asynchronously to an empty entry.
module wdest_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] dest_d,
  input  logic          wen_d,
  input  logic          load_d,
  output logic [AW-1:0] dest_q,
  output logic          wen_q,
  output logic          load_q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dest_q <= '0;
      wen_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      dest_q <= dest_d;
      wen_q  <= wen_d;
      load_q <= load_d;
    end
  end

endmodule

// File: rtl/wdest_pipe.sv
// Write-destination selector and tracker: picks the ID destination, carries it
// through STAGES (2..8) slots, and reports RAW hits and load-use stalls.
// Optional WDEST_PIPE_PERF_EN adds a saturating stall-cycle counter haz_cnt.
module wdest_pipe
  import mips_pipe_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int STAGES   = 3,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic [AW-1:0]        rd,
  input  logic [AW-1:0]        rt,
  input  logic [AW-1:0]        rs,
  input  logic                 regrt,
  input  logic                 jal,
  input  logic                 wreg,
  input  logic                 m2reg,
  input  logic                 use_rs,
  input  logic                 use_rt,
  input  logic                 bubble,
  output logic [AW-1:0]        dest_id,
  output logic [STAGES*AW-1:0] dest_pipe,
  output logic [STAGES-1:0]    wen_pipe,
  output logic [STAGES-1:0]    rs_hit,
  output logic [STAGES-1:0]    rt_hit,
  output logic                 stall_req
`ifdef WDEST_PIPE_PERF_EN
  ,
  output logic [15:0]          haz_cnt
`endif
);

  logic              wen_id;
  logic [AW-1:0]     dest_d [STAGES];
  logic [AW-1:0]     dest_q [STAGES];
  logic [STAGES-1:0] wen_d;
  logic [STAGES-1:0] wen_q;
  logic [STAGES-1:0] load_d;
  logic [STAGES-1:0] load_q;
  logic              unused_load;

  // Register 0 is never a live destination, so it can never produce a hit.
  always_comb begin
    dest_id = jal ? AW'(LINK_REG) : (regrt ? rt : rd);
    wen_id  = wreg & (dest_id != AW'(REG_ZERO));
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      dest_d[k] = '0;
    end
    wen_d  = '0;
    load_d = '0;
    if (!bubble) begin
      dest_d[0] = dest_id;
      wen_d[0]  = wen_id;
      load_d[0] = m2reg & wen_id;
    end
    for (int k = 1; k < STAGES; k++) begin
      dest_d[k] = dest_q[k-1];
      wen_d[k]  = wen_q[k-1];
      load_d[k] = load_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    wdest_stage_reg #(.AW(AW)) u_stage (
      .clk    (clk),
      .clrn   (clrn),
      .dest_d (dest_d[k]),
      .wen_d  (wen_d[k]),
      .load_d (load_d[k]),
      .dest_q (dest_q[k]),
      .wen_q  (wen_q[k]),
      .load_q (load_q[k])
    );
  end

  // The oldest slot's load flag has no consumer once it leaves the pipe.
  assign unused_load = load_q[STAGES-1];
  assign wen_pipe    = wen_q;

  always_comb begin
    dest_pipe = '0;
    rs_hit    = '0;
    rt_hit    = '0;
    for (int k = 0; k < STAGES; k++) begin
      dest_pipe[k*AW +: AW] = dest_q[k];
      rs_hit[k] = wen_q[k] & use_rs & (dest_q[k] == rs);
      rt_hit[k] = wen_q[k] & use_rt & (dest_q[k] == rt);
    end
    stall_req = load_q[0] & (rs_hit[0] | rt_hit[0]);
  end

`ifdef WDEST_PIPE_PERF_EN
  logic [15:0] haz_cnt_d;
  logic [15:0] haz_cnt_q;

  always_comb begin
    haz_cnt_d = haz_cnt_q;
    if (stall_req && (haz_cnt_q != 16'hFFFF)) begin
      haz_cnt_d = haz_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      haz_cnt_q <= '0;
    end else begin
      haz_cnt_q <= haz_cnt_d;
    end
  end

  assign haz_cnt = haz_cnt_q;
`endif

endmodule

// File: tb/tb_wdest_pipe.sv
// Table-driven bench for wdest_pipe (AW=5, STAGES=3, LINK_REG=31) with
// hand-written sequences for the async reset and link-register corner cases.
module tb_wdest_pipe;

  typedef struct {
    logic [4:0]  rd, rt, rs;
    logic        regrt, jal, wreg, m2reg, use_rs, use_rt, bubble;
    logic [4:0]  e_dest_id;
    logic [14:0] e_dest_pipe;
    logic [2:0]  e_wen, e_rs_hit, e_rt_hit;
    logic        e_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  rd, rt, rs;
  logic        regrt, jal, wreg, m2reg, use_rs, use_rt, bubble;
  logic [4:0]  dest_id;
  logic [14:0] dest_pipe;
  logic [2:0]  wen_pipe, rs_hit, rt_hit;
  logic        stall_req;
`ifdef WDEST_PIPE_PERF_EN
  logic [15:0] haz_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [32];
  vec_t v;

  always #5 clk = ~clk;

  wdest_pipe #(.AW(5), .STAGES(3), .LINK_REG(31)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .rd        (rd),
    .rt        (rt),
    .rs        (rs),
    .regrt     (regrt),
    .jal       (jal),
    .wreg      (wreg),
    .m2reg     (m2reg),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .bubble    (bubble),
    .dest_id   (dest_id),
    .dest_pipe (dest_pipe),
    .wen_pipe  (wen_pipe),
    .rs_hit    (rs_hit),
    .rt_hit    (rt_hit),
    .stall_req (stall_req)
`ifdef WDEST_PIPE_PERF_EN
    ,
    .haz_cnt   (haz_cnt)
`endif
  );

  function automatic vec_t mkVec(int rd_i, int rt_i, int rs_i, int regrt_i, int jal_i,
                                 int wreg_i, int m2reg_i, int use_rs_i, int use_rt_i,
                                 int bubble_i, int eid, int d2, int d1, int d0,
                                 int ewen, int ersh, int erth, int est);
    vec_t r;
    r.rd = 5'(rd_i);  r.rt = 5'(rt_i);  r.rs = 5'(rs_i);
    r.regrt = 1'(regrt_i);  r.jal = 1'(jal_i);  r.wreg = 1'(wreg_i);
    r.m2reg = 1'(m2reg_i);  r.use_rs = 1'(use_rs_i);  r.use_rt = 1'(use_rt_i);
    r.bubble = 1'(bubble_i);
    r.e_dest_id   = 5'(eid);
    r.e_dest_pipe = {5'(d2), 5'(d1), 5'(d0)};
    r.e_wen    = 3'(ewen);
    r.e_rs_hit = 3'(ersh);
    r.e_rt_hit = 3'(erth);
    r.e_stall  = 1'(est);
    return r;
  endfunction

  task automatic applyStimulus(input vec_t s);
    rd = s.rd;  rt = s.rt;  rs = s.rs;
    regrt = s.regrt;  jal = s.jal;  wreg = s.wreg;  m2reg = s.m2reg;
    use_rs = s.use_rs;  use_rt = s.use_rt;  bubble = s.bubble;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t s, input string tag);
    checkVal({tag, ".dest_id"},   32'(dest_id),   32'(s.e_dest_id));
    checkVal({tag, ".dest_pipe"}, 32'(dest_pipe), 32'(s.e_dest_pipe));
    checkVal({tag, ".wen_pipe"},  32'(wen_pipe),  32'(s.e_wen));
    checkVal({tag, ".rs_hit"},    32'(rs_hit),    32'(s.e_rs_hit));
    checkVal({tag, ".rt_hit"},    32'(rt_hit),    32'(s.e_rt_hit));
    checkVal({tag, ".stall_req"}, 32'(stall_req), 32'(s.e_stall));
  endtask

  initial begin
    //                rd rt rs rgt jal wr m2 urs urt bub  id  d2 d1 d0 wen rsh rth st
    // select rd / rt / link
    vecs[0]  = mkVec( 5, 9, 0, 0, 0, 0, 0, 0, 0, 0,   5,  0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec( 5, 9, 0, 1, 0, 0, 0, 0, 0, 0,   9,  0, 0, 5, 0, 0, 0, 0);
    vecs[2]  = mkVec( 5, 9, 0, 1, 1, 0, 0, 0, 0, 0,  31,  0, 5, 9, 0, 0, 0, 0);
    vecs[3]  = mkVec( 5, 9,31, 0, 1, 0, 0, 1, 0, 0,  31,  5, 9,31, 0, 0, 0, 0);
    vecs[4]  = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0,  9,31,31, 0, 0, 0, 0);
    vecs[5]  = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 31,31, 0, 0, 0, 0, 0);
    vecs[6]  = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 31, 0, 0, 0, 0, 0, 0);
    // single write walking through the stages
    vecs[7]  = mkVec( 7, 0, 0, 0, 0, 1, 0, 0, 0, 0,   7,  0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 7, 1, 0, 0, 0);
    vecs[9]  = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 7, 0, 2, 0, 0, 0);
    vecs[10] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  7, 0, 0, 4, 0, 0, 0);
    vecs[11] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 0);
    // register-0 guard
    vecs[12] = mkVec( 4, 0, 0, 1, 0, 1, 0, 1, 0, 0,   0,  0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mkVec( 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0,  0, 0, 0, 0, 0, 0, 0);
    // load-use on rs, one bubble
    vecs[14] = mkVec( 0, 8, 0, 1, 0, 1, 1, 0, 0, 0,   8,  0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mkVec( 2, 0, 8, 0, 0, 1, 0, 1, 0, 1,   2,  0, 0, 8, 1, 1, 0, 1);
    vecs[16] = mkVec( 2, 0, 8, 0, 0, 1, 0, 1, 0, 0,   2,  0, 8, 0, 2, 2, 0, 0);
    vecs[17] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  8, 0, 2, 5, 0, 0, 0);
    vecs[18] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0, 2, 0, 2, 0, 0, 0);
    vecs[19] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  2, 0, 0, 4, 0, 0, 0);
    // multi-hit on reg 3
    vecs[20] = mkVec( 3, 0, 0, 0, 0, 1, 0, 0, 0, 0,   3,  0, 0, 0, 0, 0, 0, 0);
    vecs[21] = mkVec( 3, 0, 0, 0, 0, 1, 0, 0, 0, 0,   3,  0, 0, 3, 1, 0, 0, 0);
    vecs[22] = mkVec( 3, 0, 0, 0, 0, 1, 0, 0, 0, 0,   3,  0, 3, 3, 3, 0, 0, 0);
    vecs[23] = mkVec( 0, 3, 3, 0, 0, 0, 0, 0, 1, 0,   0,  3, 3, 3, 7, 0, 7, 0);
    vecs[24] = mkVec( 0, 3, 3, 0, 0, 0, 0, 1, 1, 0,   0,  3, 3, 0, 6, 6, 6, 0);
    vecs[25] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  3, 0, 0, 4, 0, 0, 0);
    // load-use on rt
    vecs[26] = mkVec( 0,12, 0, 1, 0, 1, 1, 0, 0, 0,  12,  0, 0, 0, 0, 0, 0, 0);
    vecs[27] = mkVec( 0,12, 0, 0, 0, 0, 0, 0, 1, 1,   0,  0, 0,12, 1, 0, 1, 1);
    vecs[28] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0,  0,12, 0, 2, 0, 0, 0);
    vecs[29] = mkVec( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 12, 0, 0, 4, 0, 0, 0);
    // load flag without write enable never stalls
    vecs[30] = mkVec( 6, 0, 0, 0, 0, 0, 1, 0, 0, 0,   6,  0, 0, 0, 0, 0, 0, 0);
    vecs[31] = mkVec( 0, 0, 6, 0, 0, 0, 0, 1, 0, 0,   0,  0, 0, 6, 0, 0, 0, 0);

    // reset state, dest_id still live during reset
    clrn = 1'b0;
    applyStimulus(mkVec(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput(mkVec(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0), "reset");
    @(negedge clk);
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 clrn = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], $sformatf("row%0d", i));
    end
`ifdef WDEST_PIPE_PERF_EN
    checkVal("haz_cnt_table", 32'(haz_cnt), 32'd2);
`endif

    // jal with wreg=1 is a live write to r31, then load into r10 behind it
    @(negedge clk);
    v = mkVec(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 31, 0, 6, 0, 0, 0, 0, 0);
    applyStimulus(v); #1; checkOutput(v, "jal_wr");
    @(negedge clk);
    v = mkVec(10, 0, 31, 0, 0, 1, 1, 1, 0, 0, 10, 6, 0, 31, 1, 1, 0, 0);
    applyStimulus(v); #1; checkOutput(v, "jal_hit");
    @(negedge clk);
    v = mkVec(11, 0, 10, 0, 0, 1, 0, 1, 0, 0, 11, 0, 31, 10, 3, 1, 0, 1);
    applyStimulus(v); #1; checkOutput(v, "pre_reset");

    // asynchronous reset mid-cycle wipes all in-flight entries
    #2 clrn = 1'b0;
    #1;
    v = mkVec(11, 0, 10, 0, 0, 1, 0, 1, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(v, "async_reset");
    @(posedge clk); #1;
    checkOutput(v, "reset_hold");
    @(negedge clk);
    #2 clrn = 1'b1;
    @(posedge clk); #1;
    v = mkVec(11, 0, 10, 0, 0, 1, 0, 1, 0, 0, 11, 0, 0, 11, 1, 0, 0, 0);
    checkOutput(v, "post_release");
`ifdef WDEST_PIPE_PERF_EN
    checkVal("haz_cnt_reset", 32'(haz_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
